// File: rtl/cmd_queue_loader_pkg.sv
// Shared types for the command-queue producer.
//   cmd_t          : one command word as stored in command memory and the FIFO
//   CMD_DEPTH      : default command FIFO depth (entries, power of 2)
//   OCC_W          : width of an occupancy count for a CMD_DEPTH-entry FIFO
//   loader_state_e : cmd_queue_loader FSM states
package cmd_queue_loader_pkg;

  typedef logic [31:0] cmd_t;

  localparam int unsigned CMD_DEPTH = 16;
  localparam int unsigned OCC_W     = $clog2(CMD_DEPTH) + 1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StWait,
    StPush,
    StDone
  } loader_state_e;

endpackage

// File: rtl/cmd_queue_loader_occ_counter.sv
// Up/down occupancy tracker for a FIFO producer.
//   i_clk, i_rstn : clock, synchronous active-low reset
//   i_inc         : producer write strobe (ignored once the count reaches DEPTH)
//   i_dec         : consumer read strobe (ignored at zero, like the FIFO's empty guard)
//   o_count       : current fill level, 0..DEPTH
//   o_full        : o_count == DEPTH
module cmd_queue_loader_occ_counter
  import cmd_queue_loader_pkg::*;
#(
  parameter int unsigned DEPTH = CMD_DEPTH,
  parameter int unsigned WIDTH = OCC_W
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_count,
  output logic             o_full
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             inc_ok, dec_ok;

  always_comb begin
    inc_ok  = i_inc && (count_q != WIDTH'(DEPTH));
    dec_ok  = i_dec && (count_q != '0);
    count_d = count_q;
    case ({inc_ok, dec_ok})
      2'b10:   count_d = count_q + WIDTH'(1);
      2'b01:   count_d = count_q - WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;
  assign o_full  = (count_q == WIDTH'(DEPTH));

endmodule

// File: rtl/cmd_queue_loader.sv
// Command-queue producer: copies i_num_cmds words starting at i_base_addr from command
// memory into the command FIFO, one word every three cycles, stalling while the FIFO
// is full. FIFO fill level is tracked locally from our writes and the issuer's reads.
//   i_clk, i_rstn              : clock, synchronous active-low reset (shared with the FIFO)
//   i_start, i_base_addr,
//   i_num_cmds, i_abort        : host control
//   o_mem_rd, o_mem_addr,
//   i_mem_data                 : command memory read port, data one cycle after o_mem_rd
//   o_fifo_write, o_fifo_data  : FIFO write port
//   i_fifo_read                : snoop of the issuer's FIFO read strobe
//   o_occupancy                : tracked FIFO fill level
//   o_busy, o_done, o_drained  : status
module cmd_queue_loader
  import cmd_queue_loader_pkg::*;
#(
  parameter int unsigned CMD_W  = $bits(cmd_t),
  parameter int unsigned DEPTH  = CMD_DEPTH,
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned CNT_W  = 18
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_start,
  input  logic [ADDR_W-1:0]      i_base_addr,
  input  logic [CNT_W-1:0]       i_num_cmds,
  input  logic                   i_abort,
  output logic                   o_mem_rd,
  output logic [ADDR_W-1:0]      o_mem_addr,
  input  logic [CMD_W-1:0]       i_mem_data,
  output logic                   o_fifo_write,
  output logic [CMD_W-1:0]       o_fifo_data,
  input  logic                   i_fifo_read,
  output logic [$clog2(DEPTH):0] o_occupancy,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_drained
);

  loader_state_e    state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [CMD_W-1:0]  hold_q, hold_d;
  // Set for the first DONE cycle after a zero-length start, so o_done still pulses once.
  logic              zero_done_q, zero_done_d;

  logic occ_full;
  logic abort_now;
  logic take_start;

  assign abort_now  = i_abort && (state_q != StIdle);
  // In DONE an abort outranks a simultaneous start.
  assign take_start = i_start &&
                      ((state_q == StIdle) || ((state_q == StDone) && !i_abort));

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    hold_d       = hold_q;
    zero_done_d  = 1'b0;
    o_mem_rd     = 1'b0;
    o_mem_addr   = '0;
    o_fifo_write = 1'b0;
    o_done       = zero_done_q && !abort_now;

    unique case (state_q)
      StIdle, StDone: begin
        if (take_start) begin
          addr_d      = i_base_addr;
          remaining_d = i_num_cmds;
          if (i_num_cmds == '0) begin
            state_d     = StDone;
            zero_done_d = 1'b1;
          end else begin
            state_d = StFetch;
          end
        end else if (abort_now) begin
          state_d = StIdle;
        end
      end
      StFetch: begin
        o_mem_rd   = 1'b1;
        o_mem_addr = addr_q;
        state_d    = abort_now ? StIdle : StWait;
      end
      StWait: begin
        hold_d  = i_mem_data;
        state_d = abort_now ? StIdle : StPush;
      end
      StPush: begin
        if (abort_now) begin
          state_d = StIdle;
        end else if (!occ_full) begin
          o_fifo_write = 1'b1;
          addr_d       = addr_q + ADDR_W'(1);
          remaining_d  = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            o_done  = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StFetch;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      hold_q      <= '0;
      zero_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      hold_q      <= hold_d;
      zero_done_q <= zero_done_d;
    end
  end

  cmd_queue_loader_occ_counter #(
    .DEPTH (DEPTH),
    .WIDTH ($clog2(DEPTH) + 1)
  ) u_occ_counter (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_inc   (o_fifo_write),
    .i_dec   (i_fifo_read),
    .o_count (o_occupancy),
    .o_full  (occ_full)
  );

  assign o_fifo_data = hold_q;
  assign o_busy      = (state_q == StFetch) || (state_q == StWait) || (state_q == StPush);
  assign o_drained   = (state_q == StDone) && (o_occupancy == '0);

endmodule
